spmv_resp_unpack: RTL and testbench

SPMV_RESP_UNPACK -- requirements
Module: spmv_resp_unpack

---
 rtl/spmv_pkg.sv | 25 ++
 rtl/spmv_line_buf.sv | 25 ++
 rtl/spmv_resp_unpack.sv | 138 +++++++++++++
 tb/tb_spmv_resp_unpack.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spmv_pkg.sv
// Shared types and sizing for the SpMV response reorder/unpack path.
// The NoC line width comes from DCP_NOC_RES_DATA_SIZE, which defaults to 512 bits.
`ifndef DCP_NOC_RES_DATA_SIZE
`define DCP_NOC_RES_DATA_SIZE 512
`endif

package spmv_pkg;

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_PENDING = 2'd1,
    SLOT_FILLED  = 2'd2
  } slot_state_e;

  typedef enum logic {
    UNPACK_IDLE  = 1'b0,
    UNPACK_DRAIN = 1'b1
  } unpack_state_e;

  localparam int SPMV_ROB_DEPTH      = 8;
  localparam int SPMV_ELEM_W         = 64;
  localparam int SPMV_LINE_W         = `DCP_NOC_RES_DATA_SIZE;
  localparam int SPMV_ELEMS_PER_LINE = SPMV_LINE_W / SPMV_ELEM_W;

endpackage

// File: rtl/spmv_line_buf.sv
// Line storage for the reorder slots: one synchronous write port and one
// asynchronous read port. Contents are deliberately left unreset.
module spmv_line_buf
  import spmv_pkg::*;
#(
  parameter int DEPTH = SPMV_ROB_DEPTH,
  parameter int WIDTH = SPMV_LINE_W
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/spmv_resp_unpack.sv
// Reorder buffer that restores issue order of memory responses and streams
// each line out as ELEM_W elements. Define SPMV_UNPACK_PERF_EN for perf counters.
module spmv_resp_unpack
  import spmv_pkg::*;
#(
  parameter int DEPTH  = SPMV_ROB_DEPTH,
  parameter int ELEM_W = SPMV_ELEM_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_issue,
  output logic                     issue_ok,
  output logic [$clog2(DEPTH)-1:0] issue_tag,
  input  logic                     mem_resp_val,
  input  logic [5:0]               mem_resp_transid,
  input  logic [SPMV_LINE_W-1:0]   mem_resp_data,
  output logic                     elem_val,
  input  logic                     elem_ready,
  output logic [ELEM_W-1:0]        elem_data,
  output logic                     elem_last,
  output logic                     err,
  output logic [31:0]              perf_lines,
  output logic [31:0]              perf_stall
);

  localparam int               PTR_W     = $clog2(DEPTH);
  localparam int               N         = SPMV_LINE_W / ELEM_W;
  localparam int               IDX_W     = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N - 1);
  localparam logic [6:0]       DEPTH_LIM = 7'(DEPTH);

  slot_state_e              slot_q [DEPTH];
  unpack_state_e            state_q;
  logic [PTR_W-1:0]         head_q, tail_q, head_nxt, resp_slot;
  logic [IDX_W-1:0]         idx_q;
  logic                     elem_val_q, err_q;
  logic                     resp_ok, resp_bad, issue_bad, handshake, line_done;
  logic [SPMV_LINE_W-1:0]   line_rd;
  logic [N-1:0][ELEM_W-1:0] line_elems;

  // Only PENDING slots accept data, so a FILLED line being drained is never overwritten.
  assign issue_ok  = (slot_q[tail_q] == SLOT_FREE);
  assign issue_tag = tail_q;
  assign resp_slot = mem_resp_transid[PTR_W-1:0];
  assign resp_ok   = mem_resp_val && ({1'b0, mem_resp_transid} < DEPTH_LIM) &&
                     (slot_q[resp_slot] == SLOT_PENDING);
  assign resp_bad  = mem_resp_val && !resp_ok;
  assign issue_bad = req_issue && !issue_ok;
  assign handshake = elem_val_q && elem_ready;
  assign line_done = handshake && (idx_q == IDX_LAST);
  assign head_nxt  = head_q + PTR_W'(1);

  spmv_line_buf #(.DEPTH(DEPTH), .WIDTH(SPMV_LINE_W)) u_line_buf (
    .clk     (clk),
    .wr_en   (resp_ok),
    .wr_addr (resp_slot),
    .wr_data (mem_resp_data),
    .rd_addr (head_q),
    .rd_data (line_rd)
  );

  assign line_elems = line_rd;
  assign elem_data  = line_elems[idx_q];
  assign elem_val   = elem_val_q;
  assign elem_last  = elem_val_q && (idx_q == IDX_LAST);
  assign err        = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= SLOT_FREE;
      head_q     <= '0;
      tail_q     <= '0;
      idx_q      <= '0;
      state_q    <= UNPACK_IDLE;
      elem_val_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (req_issue && issue_ok) begin
        slot_q[tail_q] <= SLOT_PENDING;
        tail_q         <= tail_q + PTR_W'(1);
      end
      if (resp_ok) slot_q[resp_slot] <= SLOT_FILLED;
      if (issue_bad || resp_bad) err_q <= 1'b1;

      // Issue, fill and free always hit distinct slots (FREE, PENDING, FILLED).
      case (state_q)
        UNPACK_IDLE: begin
          if (slot_q[head_q] == SLOT_FILLED) begin
            state_q    <= UNPACK_DRAIN;
            elem_val_q <= 1'b1;
            idx_q      <= '0;
          end
        end
        UNPACK_DRAIN: begin
          if (handshake) begin
            if (line_done) begin
              slot_q[head_q] <= SLOT_FREE;
              head_q         <= head_nxt;
              idx_q          <= '0;
              if (slot_q[head_nxt] != SLOT_FILLED) begin
                state_q    <= UNPACK_IDLE;
                elem_val_q <= 1'b0;
              end
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        default: begin
          state_q    <= UNPACK_IDLE;
          elem_val_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPMV_UNPACK_PERF_EN
  logic [31:0] perf_lines_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_lines_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (line_done) perf_lines_q <= perf_lines_q + 32'd1;
      if (elem_val_q && !elem_ready && (perf_stall_q != 32'hFFFF_FFFF))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_lines = perf_lines_q;
  assign perf_stall = perf_stall_q;
`else
  assign perf_lines = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_spmv_resp_unpack.sv
// Scoreboard bench for spmv_resp_unpack: directed scenarios plus random traffic,
// checked against an issue-order line model kept in the bench.
module tb_spmv_resp_unpack;
  import spmv_pkg::*;

  localparam int DEPTH  = 8;
  localparam int ELEM_W = 64;
  localparam int LINE_W = SPMV_LINE_W;
  localparam int N      = LINE_W / ELEM_W;
  localparam int PTR_W  = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_issue = 1'b0;
  logic              mem_resp_val = 1'b0;
  logic [5:0]        mem_resp_transid = '0;
  logic [LINE_W-1:0] mem_resp_data = '0;
  logic              elem_ready = 1'b0;
  logic              issue_ok, elem_val, elem_last, err;
  logic [PTR_W-1:0]  issue_tag;
  logic [ELEM_W-1:0] elem_data;
  logic [31:0]       perf_lines, perf_stall;

  always #5 clk = ~clk;

  spmv_resp_unpack #(.DEPTH(DEPTH), .ELEM_W(ELEM_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_issue        (req_issue),
    .issue_ok         (issue_ok),
    .issue_tag        (issue_tag),
    .mem_resp_val     (mem_resp_val),
    .mem_resp_transid (mem_resp_transid),
    .mem_resp_data    (mem_resp_data),
    .elem_val         (elem_val),
    .elem_ready       (elem_ready),
    .elem_data        (elem_data),
    .elem_last        (elem_last),
    .err              (err),
    .perf_lines       (perf_lines),
    .perf_stall       (perf_stall)
  );

  typedef struct packed {
    logic [ELEM_W-1:0] data;
    logic              last;
  } exp_t;

  // Reference model: lines leave strictly in issue order once their data is known.
  exp_t              exp_q[$];
  int                ord_q[$];
  slot_state_e       m_state [DEPTH];
  logic [LINE_W-1:0] m_line [DEPTH];
  int                m_head, m_tail, m_used, hs_cnt, wait_cnt, m_tag;
  bit                m_err, m_valid, prev_mid_line;
  int unsigned       m_lines, m_stall;
  exp_t              m_e;
  int                vectors = 0;
  int                miscompares = 0;
  int                pend[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare against the model state of past edges, then fold in this cycle's events.
  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("issue_ok", issue_ok, m_used < DEPTH);
      checkOutput("issue_tag", issue_tag, m_tail);
      checkOutput("err", err, m_err);
`ifdef SPMV_UNPACK_PERF_EN
      checkOutput("perf_lines", perf_lines, m_lines);
      checkOutput("perf_stall", perf_stall, m_stall);
`else
      checkOutput("perf_lines", perf_lines, 0);
      checkOutput("perf_stall", perf_stall, 0);
`endif
      if (exp_q.size() == 0) begin
        checkOutput("elem_val_idle", elem_val, 0);
        wait_cnt = 0;
      end else if (!elem_val) begin
        wait_cnt++;
        if (wait_cnt > 3) begin
          checkOutput("elem_val_latency", elem_val, 1);
          wait_cnt = 0;
        end
      end else begin
        wait_cnt = 0;
      end
      if (prev_mid_line) checkOutput("no_bubble", elem_val, 1);
      if (elem_val && exp_q.size() > 0) begin
        checkOutput("elem_data", elem_data, exp_q[0].data);
        checkOutput("elem_last", elem_last, exp_q[0].last);
      end

      if (rst_n) begin
        prev_mid_line = 1'b0;
        if (mem_resp_val) begin
          if (mem_resp_transid >= DEPTH || m_state[mem_resp_transid] != SLOT_PENDING) begin
            m_err = 1'b1;
          end else begin
            m_state[mem_resp_transid] = SLOT_FILLED;
            m_line[mem_resp_transid]  = mem_resp_data;
          end
        end
        while (ord_q.size() > 0 && m_state[ord_q[0]] == SLOT_FILLED) begin
          m_tag = ord_q.pop_front();
          for (int i = 0; i < N; i++) begin
            m_e.data = ELEM_W'(m_line[m_tag] >> (i * ELEM_W));
            m_e.last = (i == N - 1);
            exp_q.push_back(m_e);
          end
        end
        if (req_issue) begin
          if (m_used < DEPTH) begin
            m_state[m_tail] = SLOT_PENDING;
            ord_q.push_back(m_tail);
            m_tail = (m_tail + 1) % DEPTH;
            m_used++;
          end else begin
            m_err = 1'b1;
          end
        end
        if (elem_val && elem_ready && exp_q.size() > 0) begin
          m_e = exp_q.pop_front();
          hs_cnt++;
          if (m_e.last) begin
            m_state[m_head] = SLOT_FREE;
            m_head = (m_head + 1) % DEPTH;
            m_used--;
            m_lines++;
          end else begin
            prev_mid_line = 1'b1;
          end
        end
        if (elem_val && !elem_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
      end
    end
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) m_state[i] = SLOT_FREE;
      exp_q.delete();
      ord_q.delete();
      m_head = 0; m_tail = 0; m_used = 0; hs_cnt = 0; wait_cnt = 0;
      m_err = 1'b0; m_lines = 0; m_stall = 0; prev_mid_line = 1'b0;
      m_valid = 1'b1;
    end
  end

  function automatic logic [LINE_W-1:0] randLine();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic applyStimulus(input logic issue, input logic rv, input int tid, input logic rdy);
    req_issue        = issue;
    mem_resp_val     = rv;
    mem_resp_transid = 6'(tid);
    mem_resp_data    = rv ? randLine() : '0;
    elem_ready       = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  task automatic drainAll();
    int c;
    c = 0;
    while ((exp_q.size() > 0 || elem_val) && c < 300) begin
      applyStimulus(0, 0, 0, 1);
      c++;
    end
    checkOutput("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic waitHandshakes(input int n);
    int c;
    c = 0;
    while (hs_cnt < n && c < 50) begin
      applyStimulus(0, 0, 0, 1);
      c++;
    end
    checkOutput("hs_timeout", hs_cnt, n);
  endtask

  initial begin
    doReset();
    checkOutput("reset_issue_ok", issue_ok, 1);
    checkOutput("reset_elem_val", elem_val, 0);

    // In-order traffic: three lines, full throughput
    for (int t = 0; t < 3; t++) applyStimulus(1, 0, 0, 1);
    for (int t = 0; t < 3; t++) applyStimulus(0, 1, t, 1);
    drainAll();
    checkOutput("inorder_count", hs_cnt, 3 * N);
`ifdef SPMV_UNPACK_PERF_EN
    checkOutput("inorder_perf_lines", perf_lines, 3);
`endif

    // Out-of-order responses: nothing may appear before tag 0
    doReset();
    for (int t = 0; t < 4; t++) applyStimulus(1, 0, 0, 1);
    applyStimulus(0, 1, 3, 1);
    applyStimulus(0, 1, 1, 1);
    applyStimulus(0, 1, 2, 1);
    for (int t = 0; t < 4; t++) applyStimulus(0, 0, 0, 1);
    checkOutput("ooo_hold", elem_val, 0);
    applyStimulus(0, 1, 0, 1);
    drainAll();
    checkOutput("ooo_count", hs_cnt, 4 * N);

    // Backpressure mid-line
    doReset();
    applyStimulus(1, 0, 0, 1);
    applyStimulus(0, 1, 0, 1);
    waitHandshakes(3);
    for (int t = 0; t < 5; t++) applyStimulus(0, 0, 0, 0);
    drainAll();
`ifdef SPMV_UNPACK_PERF_EN
    checkOutput("bp_perf_stall", perf_stall, 5);
`endif

    // Full and wrap
    doReset();
    for (int t = 0; t < DEPTH; t++) applyStimulus(1, 0, 0, 1);
    checkOutput("full_issue_ok", issue_ok, 0);
    checkOutput("full_issue_tag", issue_tag, 0);
    for (int t = 0; t < DEPTH; t++) applyStimulus(0, 1, t, 1);
    drainAll();
    applyStimulus(1, 0, 0, 1);
    checkOutput("wrap_issue_tag", issue_tag, 1);
    applyStimulus(0, 1, 0, 1);
    drainAll();

    // Protocol errors: FREE-slot response, out-of-range transid, issue while full
    doReset();
    applyStimulus(0, 1, 2, 1);
    applyStimulus(1, 0, 0, 1);
    applyStimulus(0, 1, 9, 1);
    checkOutput("err_set", err, 1);
    applyStimulus(1, 0, 0, 1);
    applyStimulus(1, 0, 0, 1);
    for (int t = 0; t < 3; t++) applyStimulus(0, 1, t, 1);
    drainAll();
    for (int t = 0; t < DEPTH + 1; t++) applyStimulus(1, 0, 0, 1);
    for (int t = 3; t < DEPTH + 3; t++) applyStimulus(0, 1, t % DEPTH, 1);
    drainAll();
    checkOutput("err_sticky", err, 1);

    // Reset in the middle of a drain
    doReset();
    checkOutput("err_cleared", err, 0);
    applyStimulus(1, 0, 0, 1);
    applyStimulus(1, 0, 0, 1);
    applyStimulus(0, 1, 0, 1);
    applyStimulus(0, 1, 1, 1);
    waitHandshakes(3);
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 1);
    rst_n = 1'b1;
    checkOutput("rst_mid_elem_val", elem_val, 0);
    checkOutput("rst_mid_issue_ok", issue_ok, 1);
    checkOutput("rst_mid_issue_tag", issue_tag, 0);

    // Random traffic
    doReset();
    for (int c = 0; c < 3000; c++) begin
      logic iss, rv, rdy;
      int   tid;
      pend.delete();
      for (int s = 0; s < DEPTH; s++) if (m_state[s] == SLOT_PENDING) pend.push_back(s);
      iss = (m_used < DEPTH) && ($urandom_range(1, 0) == 1);
      rv  = (pend.size() > 0) && ($urandom_range(2, 0) == 0);
      tid = rv ? pend[$urandom_range(pend.size() - 1, 0)] : 0;
      rdy = ($urandom_range(3, 0) != 0);
      applyStimulus(iss, rv, tid, rdy);
    end
    for (int c = 0; c < 4 * DEPTH; c++) begin
      pend.delete();
      for (int s = 0; s < DEPTH; s++) if (m_state[s] == SLOT_PENDING) pend.push_back(s);
      if (pend.size() > 0) applyStimulus(0, 1, pend[0], 1);
    end
    drainAll();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
